// File: rtl/i3c_dat_mem_arbiter.sv
// i3c_dat_mem_arbiter: shares the single-port DAT RAM between the HCI CSR
// path and the I3C controller FSM, and routes each 1-cycle read back to
// the port that issued it.
//
// Ports:
//   clk_i, rst_ni                : clock, async active-low reset
//   csr_* (req/write/addr/wdata/wmask -> gnt/rvalid/rdata/err) : CSR port
//   ctl_* (same shape)           : controller port, higher priority
//   mem_req/write/addr/wdata/wmask_o, mem_rdata_i : prim_ram_1p_adv sink
//
// Build option: define I3C_DAT_ARB_STARVE_GUARD_EN to add a wait counter
// that lets a starving CSR request win after MaxWait denied cycles.

package i3c_pkg;
    parameter int DatAw = 8;
endpackage

module i3c_dat_mem_arbiter
    import i3c_pkg::*;
#(
    parameter int AddrWidth = DatAw,
    parameter int Depth     = 128,
    parameter int DataWidth = 64,
    parameter int MaxWait   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 csr_req_i,
    input  logic                 csr_write_i,
    input  logic [AddrWidth-1:0] csr_addr_i,
    input  logic [DataWidth-1:0] csr_wdata_i,
    input  logic [DataWidth-1:0] csr_wmask_i,
    output logic                 csr_gnt_o,
    output logic                 csr_rvalid_o,
    output logic [DataWidth-1:0] csr_rdata_o,
    output logic                 csr_err_o,

    input  logic                 ctl_req_i,
    input  logic                 ctl_write_i,
    input  logic [AddrWidth-1:0] ctl_addr_i,
    input  logic [DataWidth-1:0] ctl_wdata_i,
    input  logic [DataWidth-1:0] ctl_wmask_i,
    output logic                 ctl_gnt_o,
    output logic                 ctl_rvalid_o,
    output logic [DataWidth-1:0] ctl_rdata_o,
    output logic                 ctl_err_o,

    output logic                 mem_req_o,
    output logic                 mem_write_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    output logic [DataWidth-1:0] mem_wmask_o,
    input  logic [DataWidth-1:0] mem_rdata_i
);

    // One extra bit so Depth == 2**AddrWidth still compares correctly.
    localparam logic [AddrWidth:0] DepthW = (AddrWidth+1)'(Depth);

    if (MaxWait < 1) begin : g_bad_maxwait
        $error("MaxWait must be at least 1");
    end

    logic                 w_boost;
    logic                 w_csr_gnt;
    logic                 w_ctl_gnt;
    logic                 w_any_gnt;
    logic                 w_write;
    logic                 w_in_range;
    logic [AddrWidth-1:0] w_addr;
    logic [DataWidth-1:0] w_wdata;
    logic [DataWidth-1:0] w_wmask;

    logic                 r_tag_valid;
    logic                 r_tag_owner;  // 1 = controller
    logic                 r_tag_err;

    // Controller wins unless the starvation guard has fired.
    assign w_csr_gnt = csr_req_i & (~ctl_req_i | w_boost);
    assign w_ctl_gnt = ctl_req_i & ~w_csr_gnt;
    assign w_any_gnt = w_csr_gnt | w_ctl_gnt;

    assign csr_gnt_o = w_csr_gnt;
    assign ctl_gnt_o = w_ctl_gnt;

`ifdef I3C_DAT_ARB_STARVE_GUARD_EN
    localparam int WaitW = $clog2(MaxWait + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MaxWait);

    logic [WaitW-1:0] r_wait;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wait <= '0;
        end else if (!csr_req_i || w_csr_gnt) begin
            r_wait <= '0;
        end else if (r_wait != WaitMax) begin
            r_wait <= r_wait + WaitW'(1);
        end
    end

    assign w_boost = (r_wait == WaitMax);
`else
    assign w_boost = 1'b0;
`endif

    // Granted requester's attributes; all zero when nobody is granted.
    always_comb begin
        w_addr  = '0;
        w_write = 1'b0;
        w_wdata = '0;
        w_wmask = '0;
        unique case (1'b1)
            w_ctl_gnt: begin
                w_addr  = ctl_addr_i;
                w_write = ctl_write_i;
                w_wdata = ctl_wdata_i;
                w_wmask = ctl_wmask_i;
            end
            w_csr_gnt: begin
                w_addr  = csr_addr_i;
                w_write = csr_write_i;
                w_wdata = csr_wdata_i;
                w_wmask = csr_wmask_i;
            end
            default: ;
        endcase
    end

    assign w_in_range  = ({1'b0, w_addr} < DepthW);

    // Out-of-range accesses are granted but never reach the RAM.
    assign mem_req_o   = w_any_gnt & w_in_range;
    assign mem_write_o = mem_req_o & w_write;
    assign mem_addr_o  = w_addr;
    assign mem_wdata_o = w_wdata;
    assign mem_wmask_o = w_wmask;

    // Single in-flight read tag, overwritten every cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tag_valid <= 1'b0;
            r_tag_owner <= 1'b0;
            r_tag_err   <= 1'b0;
        end else begin
            r_tag_valid <= w_any_gnt & ~w_write;
            r_tag_owner <= w_ctl_gnt;
            r_tag_err   <= ~w_in_range;
        end
    end

    assign csr_rvalid_o = r_tag_valid & ~r_tag_owner;
    assign ctl_rvalid_o = r_tag_valid &  r_tag_owner;
    assign csr_err_o    = csr_rvalid_o & r_tag_err;
    assign ctl_err_o    = ctl_rvalid_o & r_tag_err;

    assign csr_rdata_o  = (csr_rvalid_o && !r_tag_err) ? mem_rdata_i : '0;
    assign ctl_rdata_o  = (ctl_rvalid_o && !r_tag_err) ? mem_rdata_i : '0;

endmodule

// File: doc/i3c_dat_mem_arbiter.md
# i3c_dat_mem_arbiter

Two-port arbiter that shares the single-port Device Address Table (DAT) RAM between the HCI CSR path (software reads/writes of DAT entries) and the I3C controller FSM (DAT lookups during command execution). It drives the `prim_ram_1p_adv` DAT memory sink signals, tracks the single in-flight read, and routes returned data to the requester that issued it. It sits inside `i3c`, between the CSR/controller logic and the exported `dat_mem_sink`/`dat_mem_src` interface.

## Interface
- `AddrWidth`, default `i3c_pkg::DatAw`: DAT word address width.
- `Depth`, default 128: number of valid DAT entries; addresses `>= Depth` are out of range.
- `DataWidth`, default 64: DAT entry width.
- `MaxWait`, default 4: consecutive denied cycles before CSR priority is boosted (guard build only).
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `csr_req_i`, in, 1: CSR request; held with attributes stable until `csr_gnt_o`.
- `csr_write_i`, in, 1: 1 = write, 0 = read.
- `csr_addr_i`, in, AddrWidth: entry address.
- `csr_wdata_i` / `csr_wmask_i`, in, DataWidth each: write data and bit mask.
- `csr_gnt_o`, out, 1: request accepted this cycle.
- `csr_rvalid_o`, out, 1: read data valid.
- `csr_rdata_o`, out, DataWidth: read data.
- `csr_err_o`, out, 1: qualifies `csr_rvalid_o`; out-of-range address.
- `ctl_req_i`, `ctl_write_i`, `ctl_addr_i`, `ctl_wdata_i`, `ctl_wmask_i`, `ctl_gnt_o`, `ctl_rvalid_o`, `ctl_rdata_o`, `ctl_err_o`: controller port, same widths and semantics as the CSR port.
- `mem_req_o`, out, 1: RAM request.
- `mem_write_o`, out, 1: RAM write enable.
- `mem_addr_o`, out, AddrWidth: RAM address.
- `mem_wdata_o` / `mem_wmask_o`, out, DataWidth each: RAM write data and mask.
- `mem_rdata_i`, in, DataWidth: RAM read data, valid one cycle after a read request.

## Operation
- Handshake: req/gnt. A transfer occurs in the cycle where `req && gnt`. At most one grant per cycle. `gnt` is never asserted without `req`.
- Arbitration, strict priority: controller over CSR. If only one side requests, that side is granted.
- RAM drive: `mem_*` is a combinational mux of the granted requester.
  - `mem_req_o = 1` only for a granted in-range access.
  - With no grant, `mem_req_o = 0` and the other `mem_*` outputs are 0.
- Out-of-range access (`addr >= Depth`):
  - Granted normally, but `mem_req_o` stays 0.
  - Read: the requester gets `rvalid = 1`, `err = 1`, `rdata = 0` in the next cycle.
  - Write: dropped silently.
- Read tracking: registered tag `{valid, owner, err}` is captured on each granted read.
  - In the next cycle, the owner's `rvalid_o` asserts and `rdata_o = mem_rdata_i`, or 0 on error.
  - The non-owner's `rvalid_o` stays 0. `rdata_o` of a port whose `rvalid_o` is 0 is 0.
- Writes produce no `rvalid`.
- Back-to-back reads, any mix of owners, are sustained at one per cycle; the tag is overwritten each cycle.

## Timing
- Grant is combinational, same cycle as the request. Read latency is 1 cycle from the grant edge to `rvalid`.
- Write completes at the grant clock edge.
- Reset values: all `*_rvalid_o`, `*_err_o`, `*_rdata_o` = 0; tag valid = 0; wait counter = 0.
  - `*_gnt_o` and `mem_*` are combinational and are 0 whenever both requests are 0.
- Reset mid-operation: an in-flight read is discarded. No `rvalid` is produced after reset deassertion.
- Simultaneous requests: exactly one grant per the arbitration rule. The loser keeps `req` high and is served in a later cycle.

## Configuration
- `I3C_DAT_ARB_STARVE_GUARD_EN` defined:
  - Saturating counter of `$clog2(MaxWait+1)` bits increments on each cycle where `csr_req_i && !csr_gnt_o`.
  - It clears on `csr_gnt_o` or when `csr_req_i` is 0.
  - When the counter equals `MaxWait`, CSR wins the next contested cycle and the counter then clears.
  - With `MaxWait = 4`, CSR waits at most 5 cycles under continuous controller load.
- Not defined: no counter; strict controller priority, and CSR may starve indefinitely.

## Test plan
- CSR write addr 5, data `0xDEAD_BEEF_0123_4567`, full mask, then CSR read addr 5 -> `csr_rvalid_o` 1 cycle after grant; data equals the written value; `csr_err_o = 0`; `ctl_rvalid_o` stays 0.
- CSR and controller both read in the same cycle (addr 2 / addr 3) -> `ctl_gnt_o = 1`, `csr_gnt_o = 0`; CSR is granted the next cycle; each port gets its own data on consecutive cycles.
- Controller reads addr 200 with `Depth = 128` -> `mem_req_o = 0`; next cycle `ctl_rvalid_o = 1`, `ctl_err_o = 1`, `ctl_rdata_o = 0`.
- Controller requests every cycle while CSR requests continuously:
  - Guard build -> CSR is granted on the 5th contested cycle.
  - Non-guard build -> CSR is never granted.
- Write with mask `0x0000_0000_FFFF_FFFF` over an entry holding all ones, using data 0 -> readback `0xFFFF_FFFF_0000_0000`.
- Assert `rst_ni` low in the cycle after a granted read -> no `rvalid` on either port after reset is released; all outputs are 0.
